// File: rtl/count_sampler.sv
// rtl/count_sampler.sv - counter sequence checker and wrap counter with snapshot FIFO
//
// Purpose:
//   Watches a free-running 4-bit upstream counter. It flags any step that is
//   neither a hold nor a +1 (mod 16), counts 15->0 wraps (mod 16), and, on
//   request, buffers {wrap_cnt, cnt_in} snapshots in a DEPTH-entry FIFO that
//   drains through a valid/ready output.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous active-low reset
//   cnt_in     in   4  upstream counter value
//   sample_req in   1  push a snapshot this cycle
//   out_data   out  8  head snapshot {wrap_cnt, cnt}, 8'h00 when empty
//   out_valid  out  1  out_data holds a buffered snapshot
//   out_ready  in   1  consumer accepts out_data
//   wrap_cnt   out  4  15->0 transitions seen, mod 16
//   seq_err    out  1  sticky sequence violation
//   ovf        out  1  sticky dropped-request flag

module count_sampler #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       sample_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] wrap_cnt,
  output logic       seq_err,
  output logic       ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // ------------------------------------------------------------------
  // Sequence tracking state
  // ------------------------------------------------------------------
  logic [3:0] r_prev_cnt;
  logic       r_prev_vld;
  logic [3:0] r_wrap_cnt;
  logic       r_seq_err;
  logic       r_ovf;

  // ------------------------------------------------------------------
  // Snapshot FIFO state
  // ------------------------------------------------------------------
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // ------------------------------------------------------------------
  // Combinational decode
  // ------------------------------------------------------------------
  logic [3:0] w_prev_inc;
  logic       w_illegal;
  logic       w_wrap;
  logic [7:0] w_snapshot;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  always_comb begin
    w_prev_inc = r_prev_cnt + 4'd1;   // 4-bit add gives the mod-16 successor

    // The first cycle after reset has nothing to compare against.
    w_illegal  = r_prev_vld && (cnt_in != r_prev_cnt) && (cnt_in != w_prev_inc);
    w_wrap     = r_prev_vld && (r_prev_cnt == 4'd15) && (cnt_in == 4'd0);

    // Snapshot carries the wrap count as it stands before this edge.
    w_snapshot = {r_wrap_cnt, cnt_in};

    w_empty    = (r_count == '0);
    w_full     = (r_count == CNT_FULL);

    // out_valid is low when empty, so out_ready is ignored there.
    w_pop      = !w_empty && out_ready;

    // A same-cycle pop frees the slot the push needs when full.
    w_push     = sample_req && (!w_full || w_pop);
    w_drop     = sample_req && w_full && !w_pop;
  end

  // ------------------------------------------------------------------
  // Sequence checker and wrap counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_cnt <= 4'd0;
      r_prev_vld <= 1'b0;
      r_wrap_cnt <= 4'd0;
      r_seq_err  <= 1'b0;
    end else begin
      r_prev_cnt <= cnt_in;
      r_prev_vld <= 1'b1;
      if (w_wrap) begin
        r_wrap_cnt <= r_wrap_cnt + 4'd1;
      end
      if (w_illegal) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Overflow flag
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written,
  // and out_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= w_snapshot;
    end
  end

  // ------------------------------------------------------------------
  // Outputs: registered state only, no path from cnt_in/sample_req
  // ------------------------------------------------------------------
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign wrap_cnt  = r_wrap_cnt;
  assign seq_err   = r_seq_err;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_count_sampler.sv
// tb/tb_count_sampler.sv - self-checking bench for count_sampler

module tb_count_sampler;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       sample_req;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] wrap_cnt;
  logic       seq_err;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_prev_vld;
  int         m_prev;
  int         m_wrap;
  bit         m_seq;
  bit         m_ovf;
  logic [7:0] m_q[$];

  count_sampler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .sample_req (sample_req),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic r, input logic [3:0] c, input logic s, input logic o);
    reset      = r;
    cnt_in     = c;
    sample_req = s;
    out_ready  = o;
  endtask

  // Advance the model on the current inputs, then take one clock edge.
  task automatic clk_step();
    logic [7:0] snap;
    bit         pop;
    bit         full;
    if (!reset) begin
      m_prev_vld = 0;
      m_prev     = 0;
      m_wrap     = 0;
      m_seq      = 0;
      m_ovf      = 0;
      m_q.delete();
    end else begin
      pop  = (m_q.size() > 0) && out_ready;
      full = (m_q.size() == DEPTH);
      snap = {m_wrap[3:0], cnt_in};
      if (pop) void'(m_q.pop_front());
      if (sample_req) begin
        if (!full || pop) m_q.push_back(snap);
        else              m_ovf = 1;
      end
      if (m_prev_vld && (int'(cnt_in) != m_prev) && (int'(cnt_in) != (m_prev + 1) % 16))
        m_seq = 1;
      if (m_prev_vld && m_prev == 15 && cnt_in == 4'd0)
        m_wrap = (m_wrap + 1) % 16;
      m_prev     = int'(cnt_in);
      m_prev_vld = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    set_in(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < cycles; i++) clk_step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 4'd7, 1'b1, 1'b1);
    do_reset(2);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
    n_vec++; if (wrap_cnt !== 4'd0) begin n_err++; $display("FAIL reset_wrap got %0d want 0", wrap_cnt); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_seq got %b want 0", seq_err); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_count_wrap();
    for (int c = 0; c < 16; c++) begin
      set_in(1'b1, 4'(c), 1'b0, 1'b1);
      clk_step();
    end
    set_in(1'b1, 4'd0, 1'b0, 1'b1); clk_step();
    set_in(1'b1, 4'd1, 1'b1, 1'b1); clk_step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", out_valid); end
    n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL wrap_data got %h want 11", out_data); end
    n_vec++; if (wrap_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_cnt got %0d want 1", wrap_cnt); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL wrap_seq got %b want 0", seq_err); end
    set_in(1'b1, 4'd1, 1'b0, 1'b1); clk_step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drain got %b want 0", out_valid); end
  endtask

  task automatic test_seq_err();
    logic [3:0] seq_a [3] = '{4'd3, 4'd4, 4'd7};
    logic [3:0] seq_b [3] = '{4'd5, 4'd5, 4'd6};
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, seq_a[i], 1'b0, 1'b0);
      clk_step();
    end
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_jump got %b want 1", seq_err); end
    for (int i = 0; i < 20; i++) clk_step();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_sticky got %b want 1", seq_err); end
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, seq_b[i], 1'b0, 1'b0);
      clk_step();
    end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_hold got %b want 0", seq_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
    do_reset(1);
    for (int c = 2; c <= 6; c++) begin
      set_in(1'b1, 4'(c), 1'b1, 1'b0);
      clk_step();
    end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    set_in(1'b1, 4'd6, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        n_err++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
      end
      clk_step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b want 0", out_valid); end
  endtask

  task automatic test_full_pass();
    logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 4'(c), 1'b1, 1'b0);
      clk_step();
    end
    n_vec++; if (out_data !== 8'h00 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL full_head got v=%b d=%h want v=1 d=00", out_valid, out_data);
    end
    set_in(1'b1, 4'd4, 1'b1, 1'b1); clk_step();
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf got %b want 0", ovf); end
    set_in(1'b1, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        n_err++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
      end
      clk_step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    set_in(1'b1, 4'd14, 1'b0, 1'b0); clk_step();
    set_in(1'b1, 4'd15, 1'b0, 1'b0); clk_step();
    set_in(1'b1, 4'd0,  1'b0, 1'b0); clk_step();
    for (int c = 1; c <= 3; c++) begin
      set_in(1'b1, 4'(c), 1'b1, 1'b0);
      clk_step();
    end
    set_in(1'b1, 4'd9, 1'b0, 1'b0); clk_step();
    n_vec++; if (out_valid !== 1'b1 || wrap_cnt !== 4'd1 || seq_err !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got v=%b w=%0d s=%b want v=1 w=1 s=1", out_valid, wrap_cnt, seq_err);
    end
    set_in(1'b0, 4'd9, 1'b1, 1'b1); clk_step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_data got %h want 00", out_data); end
    n_vec++; if (wrap_cnt !== 4'd0) begin n_err++; $display("FAIL mid_wrap got %0d want 0", wrap_cnt); end
    n_vec++; if (ovf !== 1'b0 || seq_err !== 1'b0) begin
      n_err++; $display("FAIL mid_flags got ovf=%b seq=%b want 0 0", ovf, seq_err);
    end
    set_in(1'b1, 4'd12, 1'b0, 1'b0); clk_step();
    set_in(1'b1, 4'd13, 1'b0, 1'b0); clk_step();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL mid_first got %b want 0", seq_err); end
  endtask

  task automatic test_17_wraps();
    do_reset(1);
    for (int w = 0; w < 17; w++) begin
      for (int c = 0; c < 16; c++) begin
        set_in(1'b1, 4'(c), 1'b0, 1'b0);
        clk_step();
      end
    end
    set_in(1'b1, 4'd0, 1'b0, 1'b0); clk_step();
    n_vec++; if (wrap_cnt !== 4'd1) begin n_err++; $display("FAIL wraps17 got %0d want 1", wrap_cnt); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL wraps17_seq got %b want 0", seq_err); end
  endtask

  task automatic test_random();
    logic [3:0] cur;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         r;
    do_reset(1);
    cur = 4'($urandom_range(0, 15));
    for (int cyc = 0; cyc < 2000; cyc++) begin
      r = $urandom_range(0, 99);
      if (r >= 45 && r < 93) cur = cur + 4'd1;
      else if (r >= 93)      cur = 4'($urandom_range(0, 15));
      set_in(($urandom_range(0, 99) != 0), cur, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) < 4));
      clk_step();
      exp_valid = (m_q.size() != 0);
      exp_data  = exp_valid ? m_q[0] : 8'h00;
      n_vec++; if (out_valid !== exp_valid) begin
        n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid, exp_valid);
      end
      n_vec++; if (out_data !== exp_data) begin
        n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, out_data, exp_data);
      end
      n_vec++; if (wrap_cnt !== m_wrap[3:0]) begin
        n_err++; $display("FAIL rnd_wrap cyc %0d got %0d want %0d", cyc, wrap_cnt, m_wrap);
      end
      n_vec++; if (seq_err !== m_seq) begin
        n_err++; $display("FAIL rnd_seq cyc %0d got %b want %b", cyc, seq_err, m_seq);
      end
      n_vec++; if (ovf !== m_ovf) begin
        n_err++; $display("FAIL rnd_ovf cyc %0d got %b want %b", cyc, ovf, m_ovf);
      end
    end
  endtask

  initial begin
    set_in(1'b0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_count_wrap();
    test_seq_err();
    test_overflow();
    test_full_pass();
    test_reset_mid();
    test_17_wraps();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
